mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single backing data memory (block-wide, fixed latency, req/ack handshake) between two cache controllers: port 0 = data cache refill/write-back, port 1 = instruction cache refill.
- Sits between the cache FSMs and the memory model.
- Fixed priority to port 0, with an anti-starvation override for port 1.
- One transaction in flight at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width of requests and memory.
- DATA_WIDTH, 256, block width in bits (one cache line).
- MAX_WAIT, 4, consecutive lost arbitrations after which port 1 wins over port 0.
- TIMEOUT, 64, cycles to wait for mem_ack_i before aborting; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- req0_i  in  1  port 0 request; held high until ack0_o
- addr0_i  in  ADDR_WIDTH  port 0 address
- we0_i  in  1  port 0 write (1) / read (0)
- wdata0_i  in  DATA_WIDTH  port 0 write block
- ack0_o  out  1  port 0 completion pulse
- req1_i  in  1  port 1 request
- addr1_i  in  ADDR_WIDTH  port 1 address
- we1_i  in  1  port 1 write / read
- wdata1_i  in  DATA_WIDTH  port 1 write block
- ack1_o  out  1  port 1 completion pulse
- rdata_o  out  DATA_WIDTH  read block; shared by both ports, valid with ackN_o
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  DATA_WIDTH  memory write block
- mem_ack_i  in  1  memory completion pulse
- mem_rdata_i  in  DATA_WIDTH  memory read block
- busy_o  out  1  high while a grant is active
- error_o  out  1  sticky timeout flag (0 when macro absent)

Behaviour:
- States: IDLE, GRANT0, GRANT1.
- Reset (rst_i==0 at posedge):
  - State -> IDLE.
  - mem_req_o, ack0_o, ack1_o, busy_o, error_o = 0; mem_addr_o, mem_we_o, mem_wdata_o, rdata_o = 0; wait counter = 0.
  - Reset mid-transaction abandons it silently. No ack is issued, and a late mem_ack_i after reset is ignored in IDLE.
- IDLE arbitration, evaluated each cycle:
  - req0 & !req1 -> GRANT0.
  - req1 & !req0 -> GRANT1.
  - Both high: GRANT1 if wait counter >= MAX_WAIT, else GRANT0.
  - Neither high: stay in IDLE.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each time both ports request and port 0 wins.
  - Cleared when GRANT1 is entered.
- Registered outputs on entry to GRANTn:
  - mem_addr_o, mem_we_o and mem_wdata_o are latched from port n on the transition edge.
  - mem_req_o = 1 and busy_o = 1 from the first GRANT cycle.
  - Latency: request seen in cycle N -> mem_req_o high in cycle N+1.
- In GRANTn:
  - mem_req_o is held with stable address and data until mem_ack_i is sampled high.
  - On the mem_ack_i edge: ackn_o = 1 for exactly one cycle; rdata_o <= mem_rdata_i (reads and writes alike); mem_req_o and busy_o -> 0; state -> IDLE.
- Back-to-back: IDLE lasts at least one cycle between grants, so ackn_o is low while the next arbitration occurs. The requester must drop reqn_i in the cycle after ackn_o; a reqn_i still high in that IDLE cycle is treated as a new request.
- Requester drops reqn_i during its grant: protocol violation. The transaction still completes, and ackn_o still pulses.
- mem_ack_i in IDLE: ignored.
- The non-granted ack is never asserted; ack0_o and ack1_o are never both high.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in GRANTn and clears on entry.
  - If TIMEOUT cycles elapse without mem_ack_i: mem_req_o -> 0, ackn_o pulses once, rdata_o <= 0, error_o <= 1 (sticky until reset), state -> IDLE.
  - mem_ack_i arriving on the same edge the count reaches TIMEOUT is a normal completion; error_o is not set.
- Undefined: no counter; GRANT waits indefinitely; error_o is tied 0.

Test Plan:
- Reset then req0 read addr 0x00000020, memory acks after 10 cycles with rdata 0xA5..A5 -> mem_req_o high from cycle after req, ack0_o single pulse, rdata_o = 0xA5..A5, busy_o low after.
- req0 write addr 0x40 wdata 0x1234 and req1 read addr 0x80 simultaneously -> port 0 served first (mem_we_o=1, mem_addr_o=0x40), then port 1 after one IDLE cycle; ack order ack0_o, ack1_o.
- req0 and req1 held continuously, port 0 re-requesting immediately after each ack -> port 1 granted on the 5th arbitration (after 4 losses with MAX_WAIT=4), wait counter cleared.
- rst_i driven low during GRANT1 with mem_ack_i arriving 2 cycles later -> outputs 0 at reset edge, no ack1_o, late mem_ack_i ignored.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=8, memory never acks req0 -> at cycle 8 of grant ack0_o pulses, rdata_o=0, error_o=1 and stays 1.
- With MEM_ARB_TIMEOUT_EN, mem_ack_i exactly at cycle 8 -> normal completion, error_o=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory between the D-cache (port 0) and I-cache (port 1).
// Define MEM_ARB_TIMEOUT_EN to abort grants whose memory ack never arrives.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_WAIT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic                  we0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic                  ack0_o,
  input  logic                  req1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic                  we1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack1_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  error_o
);

  localparam int WW =
    (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                r_state;
  logic [WW-1:0]         r_wait;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_req;
  logic                  r_busy;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic          w_pick0;
  logic          w_pick1;
  logic          w_done;
  logic          w_tmo;
  logic [WW-1:0] w_wait_inc;

  // Port 1 overrides port 0 only once it has lost MAX_WAIT times.
  assign w_pick1 = req1_i &
    (!req0_i | (r_wait >= WMAX));
  assign w_pick0 = req0_i & !w_pick1;
  assign w_done  = mem_ack_i | w_tmo;

  assign w_wait_inc = (r_wait >= WMAX) ?
    WMAX : r_wait + WW'(1);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] r_tcnt;
  logic          r_err;

  assign w_tmo = (r_state != IDLE) &&
    (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else if (r_state == IDLE) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
      if (w_tmo && !mem_ack_i)
        r_err <= 1'b1;
    end
  end

  assign error_o = r_err;
`else
  assign w_tmo   = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick0) begin
            r_state <= GRANT0;
            r_addr  <= addr0_i;
            r_we    <= we0_i;
            r_wdata <= wdata0_i;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            if (req1_i)
              r_wait <= w_wait_inc;
          end else if (w_pick1) begin
            r_state <= GRANT1;
            r_addr  <= addr1_i;
            r_we    <= we1_i;
            r_wdata <= wdata1_i;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_wait  <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (w_done) begin
            r_ack0  <= (r_state == GRANT0);
            r_ack1  <= (r_state == GRANT1);
            r_rdata <= mem_ack_i ?
              mem_rdata_i : '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0_o      = r_ack0;
  assign ack1_o      = r_ack1;
  assign rdata_o     = r_rdata;
  assign mem_req_o   = r_req;
  assign mem_addr_o  = r_addr;
  assign mem_we_o    = r_we;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int MW = 4;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req0_i, we0_i, req1_i, we1_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [DW-1:0] wdata0_i, wdata1_i;
  logic          ack0_o, ack1_o;
  logic [DW-1:0] rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          busy_o, error_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_WAIT(MW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .addr0_i(addr0_i),
    .we0_i(we0_i), .wdata0_i(wdata0_i),
    .ack0_o(ack0_o),
    .req1_i(req1_i), .addr1_i(addr1_i),
    .we1_i(we1_i), .wdata1_i(wdata1_i),
    .ack1_o(ack1_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++)
      v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    req0_i = 0; addr0_i = '0; we0_i = 0; wdata0_i = '0;
    req1_i = 0; addr1_i = '0; we1_i = 0; wdata1_i = '0;
    mem_ack_i = 0; mem_rdata_i = '0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_ack0"}, DW'(ack0_o), '0);
    check({p, "_ack1"}, DW'(ack1_o), '0);
    check({p, "_mreq"}, DW'(mem_req_o), '0);
    check({p, "_busy"}, DW'(busy_o), '0);
    check({p, "_err"}, DW'(error_o), '0);
    check({p, "_maddr"}, DW'(mem_addr_o), '0);
    check({p, "_mwe"}, DW'(mem_we_o), '0);
    check({p, "_mwdata"}, mem_wdata_o, '0);
    check({p, "_rdata"}, rdata_o, '0);
  endtask

  task automatic run_random(input int n);
    logic          p0, p1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, pmrd;
    logic          pr0, pr1, pbusy, pmack;
    logic          mbusy, cur, win;
    logic [1:0]    eack;
    int            losses, rcnt, lat;
    p0 = 0; p1 = 0; w0 = 0; w1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    pr0 = 0; pr1 = 0; pbusy = 0; pmack = 0;
    pmrd = '0; mbusy = 0; cur = 0;
    losses = 0; rcnt = 0;
    lat = int'($urandom_range(0, 5));
    for (int c = 0; c < n; c++) begin
      cyc();
      eack = 2'b00;
      if (!pbusy) begin
        if (pr0 || pr1) begin
          win = pr1 && (!pr0 || losses >= MW);
          if (win) losses = 0;
          else if (pr1)
            losses = (losses < MW) ? losses + 1 : MW;
          cur = win;
          mbusy = 1;
          check("rnd_gaddr", DW'(mem_addr_o),
                DW'(win ? a1 : a0));
          check("rnd_gwe", DW'(mem_we_o),
                DW'(win ? w1 : w0));
          check("rnd_gwdata", mem_wdata_o,
                win ? d1 : d0);
        end else begin
          mbusy = 0;
        end
      end else if (pmack) begin
        mbusy = 0;
        eack = cur ? 2'b10 : 2'b01;
        check("rnd_rdata", rdata_o, pmrd);
      end else begin
        check("rnd_haddr", DW'(mem_addr_o),
              DW'(cur ? a1 : a0));
      end
      check("rnd_busy", DW'({busy_o, mem_req_o}),
            DW'({mbusy, mbusy}));
      check("rnd_ack", DW'({ack1_o, ack0_o}),
            DW'(eack));
      check("rnd_err", DW'(error_o), '0);
      if (eack[0] ? ($urandom_range(0, 1) == 1) :
          (!p0 && $urandom_range(0, 2) == 0)) begin
        p0 = 1; a0 = $urandom;
        w0 = 1'($urandom_range(0, 1)); d0 = rnd256();
      end else if (eack[0]) begin
        p0 = 0;
      end
      if (eack[1] ? ($urandom_range(0, 1) == 1) :
          (!p1 && $urandom_range(0, 2) == 0)) begin
        p1 = 1; a1 = $urandom;
        w1 = 1'($urandom_range(0, 1)); d1 = rnd256();
      end else if (eack[1]) begin
        p1 = 0;
      end
      req0_i = p0; addr0_i = a0; we0_i = w0; wdata0_i = d0;
      req1_i = p1; addr1_i = a1; we1_i = w1; wdata1_i = d1;
      if (mem_ack_i) begin
        mem_ack_i = 0;
      end else if (mbusy) begin
        if (rcnt >= lat) begin
          mem_ack_i = 1; mem_rdata_i = rnd256();
          rcnt = 0; lat = int'($urandom_range(0, 5));
        end else begin
          rcnt++;
        end
      end else begin
        mem_ack_i = ($urandom_range(0, 7) == 0);
        mem_rdata_i = rnd256();
      end
      pr0 = p0; pr1 = p1; pbusy = mbusy;
      pmack = mem_ack_i; pmrd = mem_rdata_i;
    end
  endtask

  initial begin
    logic [DW-1:0] a5, r1, r2;
    int losses;
    logic exp1;
    a5 = {32{8'hA5}};
    idle_inputs();
    rst_i = 0;
    cyc(); cyc();
    check_zero("rst");
    rst_i = 1;
    cyc();

    // single read on port 0, memory answers after 10 cycles
    req0_i = 1; addr0_i = 32'h20; we0_i = 0;
    wdata0_i = rnd256();
    cyc();
    check("t1_mreq", DW'({mem_req_o, busy_o}), DW'(2'b11));
    check("t1_maddr", DW'(mem_addr_o), DW'(32'h20));
    check("t1_mwe", DW'(mem_we_o), '0);
    for (int i = 2; i <= 10; i++) begin
      cyc();
      check("t1_hold", DW'({mem_req_o, busy_o, ack0_o}),
            DW'(3'b110));
    end
    mem_ack_i = 1; mem_rdata_i = a5;
    cyc();
    check("t1_ack0", DW'({ack1_o, ack0_o}), DW'(2'b01));
    check("t1_rdata", rdata_o, a5);
    check("t1_idle", DW'({mem_req_o, busy_o}), '0);
    req0_i = 0; mem_ack_i = 0;
    cyc();
    check("t1_pulse", DW'(ack0_o), '0);

    // simultaneous write on 0, read on 1
    req0_i = 1; addr0_i = 32'h40; we0_i = 1;
    wdata0_i = DW'(32'h1234);
    req1_i = 1; addr1_i = 32'h80; we1_i = 0;
    wdata1_i = '0;
    cyc();
    check("t2_addr0", DW'(mem_addr_o), DW'(32'h40));
    check("t2_we0", DW'(mem_we_o), DW'(1'b1));
    check("t2_wd0", mem_wdata_o, DW'(32'h1234));
    r1 = rnd256();
    mem_ack_i = 1; mem_rdata_i = r1;
    cyc();
    check("t2_ack0", DW'({ack1_o, ack0_o}), DW'(2'b01));
    req0_i = 0; mem_ack_i = 0;
    cyc();
    check("t2_addr1", DW'(mem_addr_o), DW'(32'h80));
    check("t2_we1", DW'({mem_we_o, mem_req_o}),
          DW'(2'b01));
    check("t2_noack", DW'({ack1_o, ack0_o}), '0);
    r2 = rnd256();
    mem_ack_i = 1; mem_rdata_i = r2;
    cyc();
    check("t2_ack1", DW'({ack1_o, ack0_o}), DW'(2'b10));
    check("t2_rdata", rdata_o, r2);
    req1_i = 0; mem_ack_i = 0;
    cyc();

    // both held: port 1 wins after MAX_WAIT losses
    req0_i = 1; addr0_i = 32'h100; we0_i = 0;
    req1_i = 1; addr1_i = 32'h200; we1_i = 0;
    losses = 0;
    for (int g = 0; g < 10; g++) begin
      exp1 = (losses >= MW);
      losses = exp1 ? 0 : losses + 1;
      cyc();
      check("t3_grant", DW'(mem_addr_o),
            DW'(exp1 ? 32'h200 : 32'h100));
      mem_ack_i = 1; mem_rdata_i = rnd256();
      cyc();
      check("t3_ack", DW'({ack1_o, ack0_o}),
            DW'(exp1 ? 2'b10 : 2'b01));
      mem_ack_i = 0;
    end
    req0_i = 0; req1_i = 0;
    cyc();

    // reset during GRANT1, late memory ack ignored
    req1_i = 1; addr1_i = 32'h300; we1_i = 1;
    wdata1_i = rnd256();
    cyc();
    check("t4_grant", DW'({mem_req_o, mem_addr_o}),
          DW'({1'b1, 32'h300}));
    cyc();
    rst_i = 0; req1_i = 0;
    cyc();
    check_zero("t4_rst");
    rst_i = 1;
    cyc(); cyc();
    mem_ack_i = 1; mem_rdata_i = rnd256();
    cyc();
    check("t4_late", DW'({ack1_o, ack0_o, busy_o, mem_req_o}),
          '0);
    check("t4_rdata", rdata_o, '0);
    mem_ack_i = 0;
    cyc();
    check("t4_quiet", DW'({ack1_o, ack0_o}), '0);

    run_random(2000);
    idle_inputs();
    rst_i = 0;
    cyc(); cyc();
    rst_i = 1;
    cyc();

`ifdef MEM_ARB_TIMEOUT_EN
    req0_i = 1; addr0_i = 32'h500; we0_i = 0;
    cyc();
    r1 = rnd256() | DW'(1);
    mem_ack_i = 1; mem_rdata_i = r1;
    cyc();
    check("t5_pre", rdata_o, r1);
    req0_i = 0; mem_ack_i = 0;
    cyc();
    req0_i = 1; addr0_i = 32'h600;
    cyc();
    check("t5_grant", DW'(mem_req_o), DW'(1'b1));
    for (int k = 2; k <= TO; k++) begin
      cyc();
      check("t5_wait", DW'({mem_req_o, ack0_o, error_o}),
            DW'(3'b100));
    end
    cyc();
    check("t5_tmo_ack", DW'({ack1_o, ack0_o}), DW'(2'b01));
    check("t5_tmo_rd", rdata_o, '0);
    check("t5_tmo_err", DW'(error_o), DW'(1'b1));
    check("t5_tmo_idle", DW'({mem_req_o, busy_o}), '0);
    req0_i = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t5_sticky", DW'({error_o, ack0_o}),
            DW'(2'b10));
    end

    rst_i = 0;
    cyc(); cyc();
    check("t6_rst_err", DW'(error_o), '0);
    rst_i = 1;
    cyc();
    req0_i = 1; addr0_i = 32'h700;
    cyc();
    for (int k = 2; k <= TO; k++) begin
      cyc();
      check("t6_wait", DW'({mem_req_o, ack0_o}),
            DW'(2'b10));
    end
    r2 = rnd256();
    mem_ack_i = 1; mem_rdata_i = r2;
    cyc();
    check("t6_ack", DW'({ack1_o, ack0_o}), DW'(2'b01));
    check("t6_rdata", rdata_o, r2);
    check("t6_err", DW'(error_o), '0);
    mem_ack_i = 0; req0_i = 0;
    cyc();
    check("t6_err2", DW'(error_o), '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
